// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : opcode/operand fetch stage with wait-state memory handshake
// Revision   : 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              FULL_RESET,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_DIN,
  input  logic              MEM_READY,
  input  logic              EXEC_DONE,
  input  logic              JMP_TAKE,
  output logic [7:0]        IR,
  output logic [ADDR_W-1:0] OPERAND,
  output logic              INSTR_VALID,
  output logic              STEP_INC,
  output logic              STEP_CLEAR,
  output logic [ADDR_W-1:0] PC
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    F_LO  = 2'd1,
    F_HI  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic [7:0]        ir_q, ir_d;
  logic              mem_rd_q, mem_rd_d;
  logic              valid_q, valid_d;
  logic              inc_q, inc_d;
  logic              clr_q, clr_d;
  logic              rd_ack;

  function automatic logic has_operand(input logic [7:0] opcode);
    case (opcode)
      8'h01, 8'h02, 8'h05, 8'h06, 8'h07: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // The cycle right after reset has no read outstanding, so a READY there is ignored.
  assign rd_ack = mem_rd_q & MEM_READY;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    clr_d     = 1'b0;
    case (state_q)
      F_OP: begin
        if (rd_ack) begin
          ir_d      = MEM_DIN;
          operand_d = '0;
          pc_d      = pc_q + PC_STEP;
          state_d   = has_operand(MEM_DIN) ? F_LO : ISSUE;
        end
      end
      F_LO: begin
        if (rd_ack) begin
          operand_d[7:0] = MEM_DIN;
          pc_d           = pc_q + PC_STEP;
          state_d        = F_HI;
        end
      end
      F_HI: begin
        if (rd_ack) begin
          operand_d[ADDR_W-1:8] = (ADDR_W-8)'(MEM_DIN);
          pc_d                  = pc_q + PC_STEP;
          state_d               = ISSUE;
        end
      end
      ISSUE: begin
        if (EXEC_DONE) begin
          clr_d   = 1'b1;
          state_d = F_OP;
          if (JMP_TAKE) pc_d = operand_q;
        end
      end
      default: state_d = F_OP;
    endcase
    mem_rd_d = (state_d != ISSUE);
    valid_d  = (state_d == ISSUE);
    inc_d    = valid_d;
  end

  always_ff @(posedge CLK) begin
    if (FULL_RESET) begin
      state_q   <= F_OP;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      operand_q <= '0;
      mem_rd_q  <= 1'b0;
      valid_q   <= 1'b0;
      inc_q     <= 1'b0;
      clr_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      mem_rd_q  <= mem_rd_d;
      valid_q   <= valid_d;
      inc_q     <= inc_d;
      clr_q     <= clr_d;
    end
  end

  assign MEM_ADDR    = pc_q;
  assign MEM_RD      = mem_rd_q;
  assign IR          = ir_q;
  assign OPERAND     = operand_q;
  assign INSTR_VALID = valid_q;
  assign STEP_INC    = inc_q;
  assign STEP_CLEAR  = clr_q;
  assign PC          = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed program run against a byte-counting fetch model
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        full_reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic        mem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        jmp_take = 1'b0;
  logic [7:0]  ir;
  logic [15:0] operand;
  logic        instr_valid;
  logic        step_inc;
  logic        step_clear;
  logic [15:0] pc;

  logic [7:0]  mem [0:65535];
  int          wait_n = 0;
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_unit #(.ADDR_W(16), .RESET_PC(RESET_PC)) dut (
    .CLK(clk), .FULL_RESET(full_reset), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd),
    .MEM_DIN(mem_din), .MEM_READY(mem_ready), .EXEC_DONE(exec_done),
    .JMP_TAKE(jmp_take), .IR(ir), .OPERAND(operand), .INSTR_VALID(instr_valid),
    .STEP_INC(step_inc), .STEP_CLEAR(step_clear), .PC(pc)
  );

  assign mem_din = mem[mem_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: every read request sees wait_n low cycles before READY.
  always @(posedge clk) begin
    #1;
    if (!mem_rd) begin
      wcnt = 0;
      mem_ready = (wait_n == 0);
    end else if (wcnt < wait_n) begin
      mem_ready = 1'b0;
      wcnt++;
    end else begin
      mem_ready = 1'b1;
      wcnt = 0;
    end
  end

  // Reference model: counts bytes of the current instruction rather than tracking states.
  logic [15:0] m_pc, m_op;
  logic [7:0]  m_ir, m_byte;
  int          m_got, m_len;
  bit          m_issue, m_idle, m_clear, m_live = 1'b0;

  always @(posedge clk) begin
    if (full_reset) begin
      m_pc = RESET_PC; m_ir = 8'h00; m_op = 16'h0000;
      m_issue = 1'b0; m_idle = 1'b1; m_clear = 1'b1; m_got = 0; m_len = 1;
      m_live = 1'b1;
    end else if (m_live) begin
      m_clear = 1'b0;
      if (m_issue) begin
        if (exec_done) begin
          m_clear = 1'b1;
          m_issue = 1'b0;
          m_got   = 0;
          if (jmp_take) m_pc = m_op;
        end
      end else if (m_idle) begin
        m_idle = 1'b0;
      end else if (mem_ready) begin
        m_byte = mem[m_pc];
        if (m_got == 0) begin
          m_ir  = m_byte;
          m_op  = 16'h0000;
          m_len = (m_byte inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07}) ? 3 : 1;
        end else if (m_got == 1) begin
          m_op = {m_op[15:8], m_byte};
        end else begin
          m_op = {m_byte, m_op[7:0]};
        end
        m_pc = m_pc + 16'd1;
        m_got++;
        if (m_got == m_len) m_issue = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("mem_rd", mem_rd, !m_issue && !m_idle);
      if (!m_issue && !m_idle) check("mem_addr", mem_addr, m_pc);
      check("pc", pc, m_pc);
      check("ir", ir, m_ir);
      check("operand", operand, m_op);
      check("instr_valid", instr_valid, m_issue);
      check("step_clear", step_clear, m_clear);
      if (!(m_issue && exec_done)) check("step_inc", step_inc, m_issue);
      if (step_inc && step_clear) check("inc_clear_exclusive", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_issue(input bit stray, output int lat);
    lat = 0;
    while (!instr_valid && lat < 200) begin
      exec_done = stray && (lat == 1);
      jmp_take  = stray && (lat == 1);
      tick();
      lat++;
    end
    exec_done = 1'b0;
    jmp_take  = 1'b0;
    check("issue_reached", instr_valid, 1);
  endtask

  task automatic finish_instr(input int hold, input bit jmp);
    repeat (hold) tick();
    exec_done = 1'b1;
    jmp_take  = jmp;
    tick();
    exec_done = 1'b0;
    jmp_take  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0001] = 8'h05; mem[16'h0002] = 8'h10; mem[16'h0003] = 8'h00;
    mem[16'h0010] = 8'h05; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    mem[16'h1234] = 8'h05; mem[16'h1235] = 8'h40; mem[16'h1236] = 8'h00;
    mem[16'h0040] = 8'h06; mem[16'h0041] = 8'h00; mem[16'h0042] = 8'h20;
    mem[16'h0043] = 8'h01; mem[16'h0044] = 8'hCD; mem[16'h0045] = 8'hAB;
    mem[16'h0046] = 8'h05; mem[16'h0047] = 8'hFF; mem[16'h0048] = 8'hFF;
    mem[16'hFFFF] = 8'h02;

    full_reset = 1'b1;
    tick();
    full_reset = 1'b0;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_step_clear", step_clear, 1);
    check("rst_step_inc", step_inc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 8'h00);

    // NOP at 0000, done on first ISSUE cycle
    wait_issue(1'b0, lat);
    check("nop_lat", lat, 2);
    check("nop_ir", ir, 8'h00);
    check("nop_operand", operand, 16'h0000);
    check("nop_pc", pc, 16'h0001);
    finish_instr(0, 1'b0);
    check("nop_clear", step_clear, 1);
    check("nop_next_rd", mem_rd, 1);
    check("nop_next_addr", mem_addr, 16'h0001);

    // JUMP 0010
    wait_issue(1'b0, lat);
    check("j1_lat", lat, 3);
    check("j1_operand", operand, 16'h0010);
    finish_instr(0, 1'b1);
    check("j1_pc", pc, 16'h0010);

    // JUMP 1234 held one extra ISSUE cycle
    wait_issue(1'b0, lat);
    check("j2_operand", operand, 16'h1234);
    check("j2_pc_issue", pc, 16'h0013);
    finish_instr(1, 1'b1);
    check("j2_pc", pc, 16'h1234);
    check("j2_addr", mem_addr, 16'h1234);

    // JUMP 0040
    wait_issue(1'b0, lat);
    finish_instr(0, 1'b1);

    // JMPZ not taken
    wait_issue(1'b0, lat);
    check("jz_ir", ir, 8'h06);
    check("jz_operand", operand, 16'h2000);
    wait_n = 3;
    finish_instr(0, 1'b0);
    check("jz_pc", pc, 16'h0043);
    check("jz_addr", mem_addr, 16'h0043);

    // LDAC with 3 wait cycles per byte and a stray EXEC_DONE/JMP_TAKE during fetch
    wait_issue(1'b1, lat);
    check("ld_lat", lat, 12);
    check("ld_ir", ir, 8'h01);
    check("ld_operand", operand, 16'hABCD);
    check("ld_pc", pc, 16'h0046);
    check("ld_inc", step_inc, 1);
    wait_n = 0;
    finish_instr(3, 1'b0);

    // JUMP FFFF, then STAC straddling the address wrap
    wait_issue(1'b0, lat);
    mem[16'h0000] = 8'h11;
    mem[16'h0001] = 8'h22;
    mem[16'h0002] = 8'h03;
    mem[16'h0003] = 8'h07;
    mem[16'h0004] = 8'h55;
    mem[16'h0005] = 8'h66;
    finish_instr(0, 1'b1);
    check("wrap_start_pc", pc, 16'hFFFF);
    wait_issue(1'b0, lat);
    check("wrap_lat", lat, 3);
    check("wrap_ir", ir, 8'h02);
    check("wrap_operand", operand, 16'h2211);
    check("wrap_pc", pc, 16'h0002);
    finish_instr(0, 1'b0);

    // Opcode 03 is a 1-byte instruction
    wait_issue(1'b0, lat);
    check("op03_lat", lat, 1);
    check("op03_operand", operand, 16'h0000);
    check("op03_pc", pc, 16'h0003);
    wait_n = 2;
    finish_instr(0, 1'b0);

    // Reset while waiting on the high operand byte
    repeat (6) tick();
    check("mid_rd", mem_rd, 1);
    check("mid_addr", mem_addr, 16'h0005);
    full_reset = 1'b1;
    tick();
    full_reset = 1'b0;
    check("mid_rst_rd", mem_rd, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_clear", step_clear, 1);
    check("mid_rst_operand", operand, 16'h0000);

    // Refetch from RESET_PC: opcode 11 is 1-byte
    wait_issue(1'b0, lat);
    check("refetch_lat", lat, 4);
    check("refetch_ir", ir, 8'h11);
    check("refetch_operand", operand, 16'h0000);
    check("refetch_pc", pc, 16'h0001);
    finish_instr(0, 1'b0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control-step/opcode-decode stage of the 8-bit accumulator CPU.
- Reads the opcode byte and any 16-bit address operand from byte-wide memory, with a wait-state handshake.
- Holds the PC and presents a stable IR and operand to the decode stage.
- Drives the step counter's INC/CLEAR and applies taken jumps when execute reports completion.

Parameters:
ADDR_W, 16, memory address / PC / operand width.
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
CLK  in  1  system clock, all state updates on rising edge
FULL_RESET  in  1  synchronous, active-high reset
MEM_ADDR  out  ADDR_W  read address, equals PC during fetch reads
MEM_RD  out  1  read request
MEM_DIN  in  8  read data, valid in the cycle MEM_READY=1
MEM_READY  in  1  read complete; may stay low any number of cycles
EXEC_DONE  in  1  execute stage finished the current instruction (1-cycle pulse)
JMP_TAKE  in  1  sampled with EXEC_DONE; 1 = load PC from OPERAND
IR  out  8  current opcode byte, to decode stage
OPERAND  out  ADDR_W  address operand {hi,lo}; 0 for 1-byte instructions
INSTR_VALID  out  1  IR/OPERAND valid, execute may run
STEP_INC  out  1  to step counter INC
STEP_CLEAR  out  1  to step counter CLEAR
PC  out  ADDR_W  program counter, address of the next byte to fetch

Behaviour:
- Reset: all outputs are registered. When FULL_RESET=1 at a clock edge:
  - PC=RESET_PC, IR=8'h00, OPERAND=0.
  - MEM_RD=0, INSTR_VALID=0, STEP_INC=0, STEP_CLEAR=1 for that following cycle.
  - State goes to F_OP.
  - Reset overrides every other input, including mid-read and mid-ISSUE; the aborted read is dropped.
- States: F_OP, F_LO, F_HI, ISSUE.
- F_OP:
  - MEM_RD=1, MEM_ADDR=PC.
  - On MEM_READY: IR<=MEM_DIN, PC<=PC+1, OPERAND<=0.
  - Next state is F_LO if MEM_DIN is 8'h01, 02, 05, 06 or 07 (LDAC, STAC, JUMP, JMPZ, JPNZ); otherwise ISSUE.
  - Opcodes above 8'h0F are 1-byte and are treated as NOP downstream.
- F_LO:
  - MEM_RD=1, MEM_ADDR=PC.
  - On MEM_READY: OPERAND[7:0]<=MEM_DIN, PC<=PC+1, go to F_HI.
- F_HI:
  - MEM_RD=1, MEM_ADDR=PC.
  - On MEM_READY: OPERAND[15:8]<=MEM_DIN, PC<=PC+1, go to ISSUE.
- Read states without MEM_READY: MEM_RD, MEM_ADDR, PC and state hold. MEM_READY is ignored in ISSUE.
- MEM_RD=0 in ISSUE.
- ISSUE:
  - INSTR_VALID=1; IR and OPERAND stable.
  - STEP_INC=1 every cycle in ISSUE with EXEC_DONE=0.
  - On EXEC_DONE=1:
    - STEP_INC=0, STEP_CLEAR=1 in the next cycle.
    - INSTR_VALID drops next cycle; state goes to F_OP.
    - If JMP_TAKE=1, PC<=OPERAND; otherwise PC is unchanged.
  - EXEC_DONE outside ISSUE is ignored.
- STEP_INC and STEP_CLEAR are never both 1. STEP_CLEAR is high exactly one cycle after reset and after each EXEC_DONE.
- PC arithmetic is modulo 2^ADDR_W: FFFF+1=0000. An operand fetch straddling the wrap continues at 0000.
- Latency with MEM_READY tied high, measured from entering F_OP to the first ISSUE cycle:
  - 1-byte instruction: 1 cycle.
  - 3-byte instruction: 3 cycles.
  - Each wait cycle adds 1.
- Back-to-back: the F_OP read of the next instruction begins the cycle after EXEC_DONE.

Test Plan:
- Reset then NOP: mem[0000]=00, MEM_READY=1, EXEC_DONE pulsed at first ISSUE cycle -> IR=00, OPERAND=0000, INSTR_VALID 1 cycle, PC=0001, then STEP_CLEAR=1 and MEM_RD=1 at addr 0001.
- JUMP taken: mem[0010..0012]=05,34,12, JMP_TAKE=1 with EXEC_DONE -> OPERAND=1234, PC=0013 during ISSUE, PC=1234 after EXEC_DONE, next MEM_ADDR=1234.
- JMPZ not taken: mem=06,00,20 at 0040, JMP_TAKE=0 -> PC=0043 after EXEC_DONE, next fetch at 0043.
- Wait states: LDAC 01,CD,AB with MEM_READY low 3 cycles per byte -> MEM_ADDR/MEM_RD stable during waits, ISSUE reached after 12 cycles, OPERAND=ABCD, STEP_INC=1 for each ISSUE cycle before EXEC_DONE.
- PC wrap: PC=FFFF, mem[FFFF]=02, mem[0000]=11, mem[0001]=22 -> OPERAND=2211, PC=0002.
- Reset mid-operand: FULL_RESET during F_HI with MEM_READY=0 -> next cycle MEM_RD=0, INSTR_VALID=0, PC=RESET_PC, STEP_CLEAR=1, fetch restarts at RESET_PC.
